// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: segment patterns, the blank code and the code-to-pattern mapping.
// Patterns are {g,f,e,d,c,b,a}, active-high.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Codes 10..14 have no digit meaning and show a dash so bad data is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    logic [6:0] pattern;
    case (code)
      4'd0:       pattern = SEG_0;
      4'd1:       pattern = SEG_1;
      4'd2:       pattern = SEG_2;
      4'd3:       pattern = SEG_3;
      4'd4:       pattern = SEG_4;
      4'd5:       pattern = SEG_5;
      4'd6:       pattern = SEG_6;
      4'd7:       pattern = SEG_7;
      4'd8:       pattern = SEG_8;
      4'd9:       pattern = SEG_9;
      CODE_BLANK: pattern = SEG_BLANK;
      default:    pattern = SEG_DASH;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Purely combinational code-to-segment decoder with a force-blank input,
// shared by the display blocks.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : bcd_to_seg(code_i);

endmodule

// File: rtl/seven_seg_mux_n.sv
// N-digit time-multiplexed 7-segment driver with PWM dimming and frame-synchronous value updates.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_mux_n
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BRIGHT_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_enable,
  output logic                    frame_done
);

  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_FIRST_LIT = SLOT_W'(2);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;

  logic                    slot_wrap;
  logic                    frame_wrap;
  logic [NUM_DIGITS-1:0]   idx_onehot;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_code;
  logic                    cur_blank;
  logic [6:0]              dec_seg;
  logic                    pwm_on;

  assign slot_wrap  = (slot_cnt_q == SLOT_LAST);
  assign frame_wrap = slot_wrap && (idx_q == IDX_LAST);

  // Select the active digit's code and one-hot position from the current index.
  always_comb begin
    idx_onehot = '0;
    cur_code   = CODE_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        idx_onehot[i] = 1'b1;
        cur_code      = act_dig_q[4*i +: 4];
      end
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic lz_run;

  // A digit is blanked when it and every more significant digit hold zero; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run      = lz_run & (act_dig_q[4*i +: 4] == 4'h0);
      lz_blank[i] = lz_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign cur_blank = |(lz_blank & idx_onehot);

  seven_seg_decoder u_decoder (
    .code_i  (cur_code),
    .blank_i (cur_blank),
    .seg_o   (dec_seg)
  );

  // All-ones brightness must be fully on, which a plain compare cannot reach.
  assign pwm_on = (brightness == '1) || (pwm_q < brightness);

  // Slots 0 and 1 stay dark so the segment register settles before the anode turns on.
  assign digit_enable = ((slot_cnt_q >= SLOT_FIRST_LIT) && pwm_on) ? idx_onehot : '0;

  always_comb begin
    slot_cnt_d   = slot_wrap ? '0 : slot_cnt_q + SLOT_W'(1);
    idx_d        = idx_q;
    pwm_d        = pwm_q + BRIGHT_W'(1);
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    act_dig_d    = act_dig_q;
    act_dp_d     = act_dp_q;
    seg_d        = dec_seg;
    dp_d         = |(act_dp_q & idx_onehot);
    frame_done_d = frame_wrap;

    if (slot_wrap) begin
      idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);
    end

    if (frame_wrap && pend_valid_q) begin
      act_dig_d    = pend_dig_q;
      act_dp_d     = pend_dp_q;
      pend_valid_d = 1'b0;
    end

    // A load on the boundary cycle lands in pending and waits for the following frame.
    if (load) begin
      pend_dig_d   = digits_bcd;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// Self-checking bench for seven_seg_mux_n: a cycle-position model predicts every output each cycle,
// plus literal spot checks of decoded digits, PWM duty and frame pulses.
module tb_seven_seg_mux_n;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BW    = 4;
  localparam int FRAME = ND * RD;
  localparam int PWMP  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digits_bcd;
  logic [3:0]  dp_in;
  logic [3:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_enable;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  // Model: c counts clock edges since the last reset edge.
  int          c = 0;
  bit          mValid = 1'b0;
  bit          boundary;
  logic [15:0] mPendDig, mActDig;
  logic [3:0]  mPendDp, mActDp;
  bit          mPendV;
  logic [6:0]  mSegExp;
  logic        mDpExp, mFdExp;
  logic [3:0]  expEn;
  logic [6:0]  segTable [16];

  seven_seg_mux_n #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BRIGHT_W    (BW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .digits_bcd   (digits_bcd),
    .dp_in        (dp_in),
    .load         (load),
    .brightness   (brightness),
    .seg          (seg),
    .dp           (dp),
    .digit_enable (digit_enable),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] modelSeg(input logic [15:0] v, input int d);
    logic [3:0] code;
    code = v[d*4 +: 4];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (d*4)) == 16'h0) return 7'h00;
`endif
    return segTable[code];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, c);
    end
  endtask

  // Reference model, advanced on every rising edge from the inputs presented that cycle.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      c        = 0;
      mValid   = 1'b1;
      mPendDig = '0;
      mPendDp  = '0;
      mPendV   = 1'b0;
      mActDig  = '0;
      mActDp   = '0;
      mSegExp  = '0;
      mDpExp   = 1'b0;
      mFdExp   = 1'b0;
    end else if (mValid) begin
      boundary = ((c + 1) % FRAME) == 0;
      mSegExp  = modelSeg(mActDig, (c / RD) % ND);
      mDpExp   = mActDp[(c / RD) % ND];
      mFdExp   = boundary;
      if (boundary && mPendV) begin
        mActDig = mPendDig;
        mActDp  = mPendDp;
        mPendV  = 1'b0;
      end
      if (load) begin
        mPendDig = digits_bcd;
        mPendDp  = dp_in;
        mPendV   = 1'b1;
      end
      c++;
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (mValid) begin
      expEn = ((c % RD) >= 2 && (brightness == 4'hF || (c % PWMP) < int'(brightness)))
              ? 4'(1 << ((c / RD) % ND)) : 4'h0;
      checkOutput("model_seg", 32'(seg), 32'(mSegExp));
      checkOutput("model_dp", 32'(dp), 32'(mDpExp));
      checkOutput("model_en", 32'(digit_enable), 32'(expEn));
      checkOutput("model_frame_done", 32'(frame_done), 32'(mFdExp));
    end
  end

  task automatic applyStimulus(input logic [15:0] dig, input logic [3:0] dpv);
    #1;
    load       = 1'b1;
    digits_bcd = dig;
    dp_in      = dpv;
    @(negedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic seek(input int pos);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((c % FRAME) != pos && n < 100);
    if (n >= 100) checkOutput("seek_timeout", 32'(c % FRAME), 32'(pos));
  endtask

  task automatic countEnables(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (digit_enable != 4'h0) cnt++;
    end
  endtask

  initial begin
    int cnt;
    segTable = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h00};
    rst        = 1'b1;
    load       = 1'b0;
    digits_bcd = '0;
    dp_in      = '0;
    brightness = 4'hF;

    repeat (3) @(negedge clk);
    checkOutput("reset_seg", 32'(seg), 32'h0);
    checkOutput("reset_dp", 32'(dp), 32'h0);
    checkOutput("reset_en", 32'(digit_enable), 32'h0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("first_seg_zero", 32'(seg), 32'h3F);
    checkOutput("slot1_dark", 32'(digit_enable), 32'h0);
    @(negedge clk);
    checkOutput("first_enable_slot2", 32'(digit_enable), 32'h1);

    applyStimulus(16'h1234, 4'b0100);
    seek(0);
    seek(3);
    checkOutput("d0_seg_4", 32'(seg), 32'h66);
    checkOutput("d0_en", 32'(digit_enable), 32'h1);
    seek(RD + 3);
    checkOutput("d1_seg_3", 32'(seg), 32'h4F);
    seek(2*RD + 3);
    checkOutput("d2_seg_2", 32'(seg), 32'h5B);
    checkOutput("d2_dp", 32'(dp), 32'h1);
    checkOutput("d2_en", 32'(digit_enable), 32'h4);
    seek(3*RD + 3);
    checkOutput("d3_seg_1", 32'(seg), 32'h06);
    cnt = 0;
    for (int k = 0; k < 2*FRAME; k++) begin
      @(negedge clk);
      if (frame_done) cnt++;
    end
    checkOutput("frame_done_per_64", 32'(cnt), 32'd2);

    seek(RD + 1);
    applyStimulus(16'h5678, 4'b0000);
    seek(2*RD + 1);
    applyStimulus(16'h9999, 4'b0000);
    seek(3*RD + 3);
    checkOutput("tearfree_old_frame", 32'(seg), 32'h06);
    seek(3);
    checkOutput("tearfree_new_d0", 32'(seg), 32'h6F);
    seek(RD + 3);
    checkOutput("tearfree_new_d1", 32'(seg), 32'h6F);

    #1 brightness = 4'h0;
    countEnables(2*FRAME, cnt);
    checkOutput("bright0_dark", 32'(cnt), 32'd0);
    #1 brightness = 4'h4;
    countEnables(FRAME, cnt);
    checkOutput("bright4_duty", 32'(cnt), 32'd4);
    #1 brightness = 4'hF;
    countEnables(FRAME, cnt);
    checkOutput("brightF_duty", 32'(cnt), 32'd24);

    applyStimulus(16'hFA0F, 4'b0000);
    seek(0);
    seek(3);
    checkOutput("code_F_blank", 32'(seg), 32'h00);
    seek(RD + 3);
    checkOutput("code_0", 32'(seg), 32'h3F);
    seek(2*RD + 3);
    checkOutput("code_A_dash", 32'(seg), 32'h40);
    seek(3*RD + 3);
    checkOutput("code_F_msd_blank", 32'(seg), 32'h00);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    applyStimulus(16'h0070, 4'b0000);
    seek(0);
    seek(3);
    checkOutput("lz_d0", 32'(seg), 32'h3F);
    seek(RD + 3);
    checkOutput("lz_d1", 32'(seg), 32'h07);
    seek(2*RD + 3);
    checkOutput("lz_d2_blank", 32'(seg), 32'h00);
    seek(3*RD + 3);
    checkOutput("lz_d3_blank", 32'(seg), 32'h00);
    applyStimulus(16'h0000, 4'b1000);
    seek(0);
    seek(3);
    checkOutput("lz_all0_d0", 32'(seg), 32'h3F);
    seek(3*RD + 3);
    checkOutput("lz_all0_d3_blank", 32'(seg), 32'h00);
    checkOutput("lz_all0_d3_dp", 32'(dp), 32'h1);
`endif

    applyStimulus(16'h4321, 4'b0000);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_seg", 32'(seg), 32'h0);
    checkOutput("midreset_en", 32'(digit_enable), 32'h0);
    #1 rst = 1'b0;
    seek(0);
    seek(3);
    checkOutput("midreset_pending_lost", 32'(seg), 32'h3F);

    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      #1;
      rst  = ($urandom_range(0, 299) == 0);
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        digits_bcd = 16'($urandom);
        dp_in      = 4'($urandom);
      end
      if ($urandom_range(0, 39) == 0) brightness = 4'($urandom);
    end
    @(negedge clk);
    #1;
    rst  = 1'b0;
    load = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
